mips_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the MIPS core, with the architectural HI/LO registers. Decode issues a MULT/MULTU/DIV/DIVU/MTHI/MTLO operation with the rs/rt operand values. The block runs a 32-step shift-add multiply or restoring divide. It holds `busy` so the control path can stall MFHI/MFLO and later mul/div instructions until `done`.

---
 rtl/mips_muldiv_seq.sv | 193 +++++++++++++++++++
 tb/tb_mips_muldiv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_seq.sv
// MIPS HI/LO multiply/divide sequencer: 32-step shift-add multiply, restoring divide (divider present only with MULDIV_DIV_EN).
// Latency: accepted start at edge N -> HI/LO written and done pulsed at edge N+33; MTHI/MTLO write at the issuing edge.
// Backpressure: busy holds for the whole operation; start while busy is ignored, cancel aborts without touching HI/LO.
module mips_muldiv_seq (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_res_q, neg_res_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [32:0] div_diff;
`endif

    logic        op_mul, op_div, issue, launch;
    logic        run_step, fix_wr;
    logic        sgn_a, sgn_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] step_acc, prod;
    logic [31:0] res_hi, res_lo;

    // ---------------- issue decode ----------------
    always_comb begin
        op_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_DIV_EN
        op_div = (op == OP_DIV) || (op == OP_DIVU);
`else
        op_div = 1'b0;
`endif
        issue  = start && !cancel && (state_q == S_IDLE);
        launch = issue && (op_mul || op_div);
        // op[0] clear selects the signed flavour of both MULT and DIV
        sgn_a  = !op[0] && rs_val[31];
        sgn_b  = !op[0] && rt_val[31];
        mag_a  = sgn_a ? (32'd0 - rs_val) : rs_val;
        mag_b  = sgn_b ? (32'd0 - rt_val) : rt_val;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_RUN;
            S_RUN:   if (cancel) state_d = S_IDLE;
                     else if (cnt_q == 6'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        run_step = (state_q == S_RUN);
        fix_wr   = (state_q == S_FIX) && !cancel;
    end

    // ---------------- iteration step ----------------
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        step_acc = {mul_sum, acc_q[31:1]};
`ifdef MULDIV_DIV_EN
        // acc_q[63:31] is the remainder already shifted left, 33 bits wide
        div_diff = acc_q[63:31] - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_diff[32]) step_acc = {div_diff[31:0], acc_q[30:0], 1'b1};
            else               step_acc = {acc_q[62:0], 1'b0};
        end
`endif
    end

    // ---------------- sign fix-up ----------------
    always_comb begin
        prod   = neg_res_q ? (64'd0 - acc_q) : acc_q;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            // divide-by-zero: unsigned core already leaves |rs| in rem, so the
            // dividend-sign fix restores rs_val exactly; only LO needs forcing
            res_hi = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            res_lo = dz_q ? 32'hFFFF_FFFF
                          : (neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
        end
`endif
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = fix_wr;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
`endif
        if (launch) begin
            cnt_d     = 6'd0;
            acc_d     = {32'd0, mag_a};
            opb_d     = mag_b;
            neg_res_d = sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
            is_div_d  = op_div;
            neg_rem_d = sgn_a;
            dz_d      = (rt_val == 32'd0);
`endif
        end else if (issue && (op == OP_MTHI)) begin
            hi_d = rs_val;
        end else if (issue && (op == OP_MTLO)) begin
            lo_d = rs_val;
        end
        if (run_step) begin
            cnt_d = cnt_q + 6'd1;
            acc_d = step_acc;
        end
        if (fix_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            neg_res_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Bench for mips_muldiv_seq: vector table + random model checks, scoreboard queue, hand-written corner sequences.
module tb_mips_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_muldiv_seq dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] sb_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin p = sa * sb; return p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one mul/div, expect busy for 33 cycles and the queued result on done.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int n;
        logic [63:0] e;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        sb_q.push_back(exp);
        tick();
        start = 1'b0;
        chk({name, "_busy_on"}, {63'd0, busy}, 64'd1);
        chk({name, "_done_low"}, {63'd0, done}, 64'd0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, 33);
        chk({name, "_busy_off"}, {63'd0, busy}, 64'd0);
        if (done) begin
            if (sb_q.size() == 0) begin
                chk({name, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk({name, "_hilo"}, {hi, lo}, e);
            end
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        int seen;
        logic [2:0]  o;
        logic [31:0] a, b;

        rst_b = 1'b0; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; cancel = 1'b0;
        #2;
        chk("rst_state", {hi, lo}, 64'd0);
        chk("rst_flags", {62'd0, busy, done}, 64'd0);
        #10 rst_b = 1'b1;
        tick();

        // MTHI then MTLO on consecutive edges
        start = 1'b1; op = 3'd4; rs_val = 32'h1234_5678;
        tick();
        chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        chk("mthi_flags", {62'd0, busy, done}, 64'd0);
        op = 3'd5; rs_val = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        chk("mtlo_hilo", {hi, lo}, 64'h1234_5678_CAFE_F00D);
        chk("mtlo_flags", {62'd0, busy, done}, 64'd0);

        // reserved op and cancelled MTHI leave state alone
        start = 1'b1; op = 3'd6; rs_val = 32'h1111_1111; rt_val = 32'h2;
        tick();
        op = 3'd4; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        tick();
        chk("rsvd_cancel_hilo", {hi, lo}, 64'h1234_5678_CAFE_F00D);
        chk("rsvd_cancel_flags", {62'd0, busy, done}, 64'd0);

        // cancel at RUN step 10
        start = 1'b1; op = 3'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("cancel_busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy_after", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        chk("cancel_no_done", seen, 0);
        chk("cancel_hilo", {hi, lo}, 64'h1234_5678_CAFE_F00D);

        tbl.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        tbl.push_back('{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        tbl.push_back('{3'd1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F});
        tbl.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        tbl.push_back('{3'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{3'd0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000});
`ifdef MULDIV_DIV_EN
        tbl.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        tbl.push_back('{3'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
        tbl.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        tbl.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF});
        tbl.push_back('{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
`endif
        foreach (tbl[i])
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});

        for (int i = 0; i < 8; i++) begin
`ifdef MULDIV_DIV_EN
            o = 3'($urandom_range(0, 3));
`else
            o = 3'($urandom_range(0, 1));
`endif
            a = $urandom;
            b = $urandom;
            run_op($sformatf("rnd%0d", i), o, a, b, model(o, a, b));
        end

        // start while busy is ignored
        start = 1'b1; op = 3'd0; rs_val = 32'hFFFF_FFFD; rt_val = 32'd7;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 3'd4; rs_val = 32'hDEAD_BEEF;
        tick();
        op = 3'd1; rt_val = 32'd9;
        tick();
        start = 1'b0;
        seen = 6;
        while (!done && seen < 40) begin
            tick();
            seen++;
        end
        chk("busy_ignore_latency", seen, 33);
        chk("busy_ignore_hilo", {hi, lo}, sb_q.pop_front());

`ifndef MULDIV_DIV_EN
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd3;
        tick();
        start = 1'b0;
        chk("nodiv_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            tick();
        end
        chk("nodiv_idle", seen, 0);
        chk("nodiv_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif

        // async reset at RUN step 20
        start = 1'b1; op = 3'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #1 rst_b = 1'b0;
        #1;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_flags", {62'd0, busy, done}, 64'd0);
        #1 rst_b = 1'b1;
        tick();
        run_op("post_rst", 3'd1, 32'd3, 32'd5, 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
